pot_scan_sched: RTL and testbench

Round-robin scheduler that shares the single SPI A2D converter among the six equalizer potentiometers (LP, B1, B2, B3, HP, VOL). It paces conversions, drives the channel select, and captures each result into the corresponding pot register. The registers feed the band-scale and volume-scale stages of the equalizer core directly. A watchdog retries any conversion whose completion never arrives, so a hung converter cannot freeze the pot values.

---
 rtl/pot_scan_sched.sv | 148 ++++++++++++++
 tb/tb_pot_scan_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pot_scan_sched.sv
// Round-robin scheduler sharing one A2D converter across the six equalizer pots; all outputs registered.
// Each conversion: START pulse, WAIT for cnv_cmplt (watchdog retry on timeout), then GAP; hold stalls only in GAP.
module pot_scan_sched #(
  parameter int GAP_CYCLES = 64,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [11:0] LP_pot,
  output logic [11:0] B1_pot,
  output logic [11:0] B2_pot,
  output logic [11:0] B3_pot,
  output logic [11:0] HP_pot,
  output logic [11:0] VOL_pot,
  output logic        sweep_done,
  output logic        pots_vld,
  output logic        timeout
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {GAP, START, WAIT} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [11:0]   pot_q [6];
  logic [11:0]   pot_d [6];
  logic          strt_cnv_q, strt_cnv_d;
  logic [2:0]    chnnl_q, chnnl_d;
  logic          sweep_done_q, sweep_done_d;
  logic          pots_vld_q, pots_vld_d;
  logic          timeout_q, timeout_d;

  function automatic logic [2:0] chn_map(input logic [2:0] idx);
    case (idx)
      3'd0:    chn_map = 3'd1;
      3'd1:    chn_map = 3'd0;
      3'd2:    chn_map = 3'd4;
      3'd3:    chn_map = 3'd2;
      3'd4:    chn_map = 3'd3;
      3'd5:    chn_map = 3'd7;
      default: chn_map = 3'd1;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    idx_d        = idx_q;
    pot_d        = pot_q;
    strt_cnv_d   = 1'b0;
    sweep_done_d = 1'b0;
    pots_vld_d   = pots_vld_q;
    timeout_d    = 1'b0;
    case (state_q)
      GAP: begin
        // Counter saturates at its terminal value while hold is high.
        if (gap_cnt_q == GAP_LAST) begin
          if (!hold) begin
            state_d    = START;
            strt_cnv_d = 1'b1;
            wait_cnt_d = '0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      START: begin
        // The START clock already counts toward the watchdog limit.
        wait_cnt_d = TW'(1);
        state_d    = WAIT;
      end
      WAIT: begin
        if (cnv_cmplt) begin
          pot_d[idx_q] = res;
          idx_d        = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
          gap_cnt_d    = '0;
          state_d      = GAP;
          if (idx_q == 3'd5) begin
            sweep_done_d = 1'b1;
            pots_vld_d   = 1'b1;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end
    endcase
    chnnl_d = chn_map(idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= GAP;
      gap_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      idx_q        <= 3'd0;
      pot_q        <= '{default: '0};
      strt_cnv_q   <= 1'b0;
      chnnl_q      <= 3'd1;
      sweep_done_q <= 1'b0;
      pots_vld_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      idx_q        <= idx_d;
      pot_q        <= pot_d;
      strt_cnv_q   <= strt_cnv_d;
      chnnl_q      <= chnnl_d;
      sweep_done_q <= sweep_done_d;
      pots_vld_q   <= pots_vld_d;
      timeout_q    <= timeout_d;
    end
  end

  assign strt_cnv   = strt_cnv_q;
  assign chnnl      = chnnl_q;
  assign LP_pot     = pot_q[0];
  assign B1_pot     = pot_q[1];
  assign B2_pot     = pot_q[2];
  assign B3_pot     = pot_q[3];
  assign HP_pot     = pot_q[4];
  assign VOL_pot    = pot_q[5];
  assign sweep_done = sweep_done_q;
  assign pots_vld   = pots_vld_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pot_scan_sched.sv
// Bench for pot_scan_sched: behavioural A2D model with a capture scoreboard and an expected channel-order queue.
module tb_pot_scan_sched;
  localparam int GAP = 4;
  localparam int TMO = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = 12'h000;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, VOL_pot;
  logic        sweep_done, pots_vld, timeout;

  pot_scan_sched #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .cnv_cmplt(cnv_cmplt), .res(res),
    .strt_cnv(strt_cnv), .chnnl(chnnl),
    .LP_pot(LP_pot), .B1_pot(B1_pot), .B2_pot(B2_pot), .B3_pot(B3_pot),
    .HP_pot(HP_pot), .VOL_pot(VOL_pot),
    .sweep_done(sweep_done), .pots_vld(pots_vld), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] val;
  } cap_t;

  int total = 0;
  int bad = 0;
  int cyc = 0, starts = 0, last_strt = 0, to_cnt = 0, last_to = 0;
  int sd_cnt = 0, sd_cyc = 0, vol_cmplt_cyc = 0;
  int strt_cyc_ch [8];
  int lat = 10, cd = 0, stray_cd = 0, drop_ch = -1, res_base = 'h100, res_fix = -1;
  logic        drop_cur = 1'b0;
  logic [11:0] cur_res = 12'h000;
  logic [2:0]  cur_ch = 3'd0;
  cap_t        cap_q [$];
  logic [2:0]  exp_chn [$];
  logic [2:0]  chm [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  function automatic logic [11:0] pot_of(input logic [2:0] ch);
    case (ch)
      3'd1:    return LP_pot;
      3'd0:    return B1_pot;
      3'd4:    return B2_pot;
      3'd2:    return B3_pot;
      3'd3:    return HP_pot;
      3'd7:    return VOL_pot;
      default: return 12'h000;
    endcase
  endfunction

  // One clock: sample outputs at the falling edge, score captures, run the A2D model.
  task automatic tick();
    cap_t       e;
    logic [2:0] ec;
    @(negedge clk);
    cyc++;
    if (cap_q.size() > 0) begin
      e = cap_q.pop_front();
      total++;
      if (pot_of(e.ch) !== e.val) begin
        bad++;
        $display("FAIL capture ch%0d: got %h, expected %h", e.ch, pot_of(e.ch), e.val);
      end
    end
    if (timeout === 1'b1) begin to_cnt++; last_to = cyc; end
    if (sweep_done === 1'b1) begin sd_cnt++; sd_cyc = cyc; end
    cnv_cmplt = 1'b0;
    if (stray_cd > 0) begin
      stray_cd--;
      if (stray_cd == 0) begin cnv_cmplt = 1'b1; res = 12'hFFF; end
    end
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        if (drop_cur) drop_ch = -1;
        else begin
          cnv_cmplt = 1'b1;
          res = cur_res;
          cap_q.push_back('{cur_ch, cur_res});
          if (cur_ch == 3'd7) vol_cmplt_cyc = cyc;
        end
      end
    end
    if (strt_cnv === 1'b1) begin
      starts++;
      last_strt = cyc;
      strt_cyc_ch[chnnl] = cyc;
      if (exp_chn.size() > 0) begin
        ec = exp_chn.pop_front();
        total++;
        if (chnnl !== ec) begin
          bad++;
          $display("FAIL strt_chnnl at cyc %0d: got %0d, expected %0d", cyc, chnnl, ec);
        end
      end
      cur_ch   = chnnl;
      cd       = lat;
      drop_cur = (int'(chnnl) == drop_ch);
      cur_res  = (res_fix >= 0) ? 12'(res_fix) : 12'(res_base + int'(chnnl));
    end
  endtask

  task automatic wait_starts(input int n, input int bound);
    for (int i = 0; i < bound && starts < n; i++) tick();
    if (starts < n) begin
      total++; bad++;
      $display("FAIL wait_starts: got %0d starts, expected %0d", starts, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0;
    repeat (3) tick();
    total++; if (strt_cnv !== 1'b0) begin bad++; $display("FAIL rst_strt: got %b, expected 0", strt_cnv); end
    total++; if (chnnl !== 3'd1) begin bad++; $display("FAIL rst_chnnl: got %0d, expected 1", chnnl); end
    total++; if (pots_vld !== 1'b0) begin bad++; $display("FAIL rst_vld: got %b, expected 0", pots_vld); end
    total++; if ({timeout, sweep_done} !== 2'b00) begin bad++; $display("FAIL rst_pulses: got %b, expected 00", {timeout, sweep_done}); end
    total++;
    if ((LP_pot | B1_pot | B2_pot | B3_pot | HP_pot | VOL_pot) !== 12'h000) begin
      bad++; $display("FAIL rst_pots: got nonzero %h, expected 000", LP_pot | B1_pot | B2_pot | B3_pot | HP_pot | VOL_pot);
    end
    rst_n = 1'b1; cyc = 0; starts = 0;
  endtask

  task automatic test_sweep();
    lat = 10; res_base = 'h100;
    exp_chn = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7, 3'd1};
    wait_starts(1, 20);
    total++; if (last_strt != GAP) begin bad++; $display("FAIL first_strt: got cyc %0d, expected %0d", last_strt, GAP); end
    total++; if (pots_vld !== 1'b0) begin bad++; $display("FAIL vld_early: got %b, expected 0", pots_vld); end
    wait_starts(7, 200);
    total++;
    if (last_strt != GAP + 6 * (10 + GAP + 1)) begin
      bad++; $display("FAIL sweep_period: got cyc %0d, expected %0d", last_strt, GAP + 6 * (10 + GAP + 1));
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (pot_of(chm[i]) !== 12'h100 + 12'(chm[i])) begin
        bad++; $display("FAIL sweep_pot%0d: got %h, expected %h", i, pot_of(chm[i]), 12'h100 + 12'(chm[i]));
      end
    end
    total++; if (sd_cnt != 1) begin bad++; $display("FAIL sweep_done_cnt: got %0d, expected 1", sd_cnt); end
    total++; if (sd_cyc != vol_cmplt_cyc + 1) begin bad++; $display("FAIL sweep_done_cyc: got %0d, expected %0d", sd_cyc, vol_cmplt_cyc + 1); end
    total++; if (pots_vld !== 1'b1) begin bad++; $display("FAIL vld_set: got %b, expected 1", pots_vld); end
  endtask

  task automatic test_timeout();
    int base, t_b2;
    base = starts; res_base = 'h200; drop_ch = 4;
    exp_chn.push_back(3'd0); exp_chn.push_back(3'd4); exp_chn.push_back(3'd4); exp_chn.push_back(3'd2);
    for (int i = 0; i < 200 && to_cnt == 0; i++) tick();
    total++; if (last_to - strt_cyc_ch[4] != TMO) begin bad++; $display("FAIL to_delay: got %0d, expected %0d", last_to - strt_cyc_ch[4], TMO); end
    total++; if (B2_pot !== 12'h104) begin bad++; $display("FAIL to_b2_hold: got %h, expected 104", B2_pot); end
    total++; if (chnnl !== 3'd4) begin bad++; $display("FAIL to_chnnl: got %0d, expected 4", chnnl); end
    t_b2 = strt_cyc_ch[4];
    wait_starts(base + 3, 100);
    total++; if (strt_cyc_ch[4] - t_b2 != TMO + GAP) begin bad++; $display("FAIL retry_delay: got %0d, expected %0d", strt_cyc_ch[4] - t_b2, TMO + GAP); end
    total++; if (B2_pot !== 12'h104) begin bad++; $display("FAIL retry_b2_hold: got %h, expected 104", B2_pot); end
    wait_starts(base + 4, 100);
    total++; if (B2_pot !== 12'h204) begin bad++; $display("FAIL retry_b2: got %h, expected 204", B2_pot); end
    total++; if (to_cnt != 1) begin bad++; $display("FAIL to_cnt: got %0d, expected 1", to_cnt); end
  endtask

  task automatic test_tmo_edge();
    int base, t_hp, tc;
    base = starts; lat = TMO - 1; res_fix = 'hABC;
    exp_chn.push_back(3'd3); exp_chn.push_back(3'd7);
    wait_starts(base + 1, 100);
    t_hp = last_strt; lat = 10; res_fix = -1; tc = to_cnt;
    wait_starts(base + 2, 100);
    total++; if (to_cnt != tc) begin bad++; $display("FAIL edge_timeout: got %0d pulses, expected %0d", to_cnt, tc); end
    total++; if (HP_pot !== 12'hABC) begin bad++; $display("FAIL edge_hp: got %h, expected abc", HP_pot); end
    total++; if (last_strt - t_hp != TMO + GAP) begin bad++; $display("FAIL edge_period: got %0d, expected %0d", last_strt - t_hp, TMO + GAP); end
  endtask

  task automatic test_hold_wait();
    int base;
    base = starts; hold = 1'b1;
    repeat (40) tick();
    total++; if (VOL_pot !== 12'h207) begin bad++; $display("FAIL hold_wait_vol: got %h, expected 207", VOL_pot); end
    total++; if (starts != base) begin bad++; $display("FAIL hold_wait_stall: got %0d starts, expected %0d", starts, base); end
    total++; if (sd_cnt != 2) begin bad++; $display("FAIL hold_wait_sd: got %0d, expected 2", sd_cnt); end
  endtask

  task automatic test_hold_gap();
    int base, trel;
    base = starts;
    repeat (100) tick();
    total++; if (starts != base) begin bad++; $display("FAIL hold_gap_stall: got %0d starts, expected %0d", starts, base); end
    exp_chn.push_back(3'd1);
    hold = 1'b0; trel = cyc;
    tick();
    total++;
    if (starts != base + 1 || last_strt != trel + 1) begin
      bad++; $display("FAIL hold_release: got starts %0d at cyc %0d, expected %0d at %0d", starts, last_strt, base + 1, trel + 1);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = starts;
    exp_chn.push_back(3'd0); exp_chn.push_back(3'd4); exp_chn.push_back(3'd2); exp_chn.push_back(3'd3);
    wait_starts(base + 4, 200);
    tick(); tick();
    cd = 0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; cyc = 0; starts = 0; stray_cd = 2;
    repeat (3) tick();
    total++;
    if ((LP_pot | B1_pot | B2_pot | B3_pot | HP_pot | VOL_pot) !== 12'h000) begin
      bad++; $display("FAIL mid_rst_pots: got nonzero %h, expected 000", LP_pot | B1_pot | B2_pot | B3_pot | HP_pot | VOL_pot);
    end
    total++; if (chnnl !== 3'd1) begin bad++; $display("FAIL mid_rst_chnnl: got %0d, expected 1", chnnl); end
    total++; if (pots_vld !== 1'b0) begin bad++; $display("FAIL mid_rst_vld: got %b, expected 0", pots_vld); end
    exp_chn.push_back(3'd1);
    wait_starts(1, 20);
    total++; if (last_strt != GAP) begin bad++; $display("FAIL mid_rst_first: got cyc %0d, expected %0d", last_strt, GAP); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_timeout();
    test_tmo_edge();
    test_hold_wait();
    test_hold_gap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
